// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode/pipeline bundle for the hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NSRC = 2,
    parameter int CW   = 3
);
    logic                 ds_valid;
    logic                 ds_issue;
    logic [NSRC*AW-1:0]   ds_src;
    logic [NSRC-1:0]      ds_src_en;
    logic                 ds_is_branch;
    logic                 ds_gr_we;
    logic [AW-1:0]        ds_dest;
    logic [CW-1:0]        ds_lat;
    logic                 es_valid;
    logic                 es_gr_we;
    logic [AW-1:0]        es_dest;
    logic                 ms_valid;
    logic                 ms_gr_we;
    logic [AW-1:0]        ms_dest;
    logic                 ws_valid;
    logic                 ws_gr_we;
    logic [AW-1:0]        ws_dest;
    logic                 pipe_go;
    logic                 long_done;
    logic [AW-1:0]        long_dest;
    logic                 flush;
    logic                 ds_stall;
    logic [2*NSRC-1:0]    fwd_sel;
    logic [NREG-1:0]      sb_busy;
    logic [31:0]          stall_cnt;

    modport master (
        output ds_valid, ds_issue, ds_src, ds_src_en, ds_is_branch, ds_gr_we,
               ds_dest, ds_lat, es_valid, es_gr_we, es_dest, ms_valid, ms_gr_we,
               ms_dest, ws_valid, ws_gr_we, ws_dest, pipe_go, long_done,
               long_dest, flush,
        input  ds_stall, fwd_sel, sb_busy, stall_cnt
    );

    modport slave (
        input  ds_valid, ds_issue, ds_src, ds_src_en, ds_is_branch, ds_gr_we,
               ds_dest, ds_lat, es_valid, es_gr_we, es_dest, ms_valid, ms_gr_we,
               ms_dest, ws_valid, ws_gr_we, ws_dest, pipe_go, long_done,
               long_dest, flush,
        output ds_stall, fwd_sel, sb_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register in-flight scoreboard producing decode stall and forwarding selects
module hazard_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NSRC = 2,
    parameter int CW   = 3
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);
    localparam logic [CW-1:0] LONG = '1;

    logic [1:0]      pend [NREG];
    logic [CW-1:0]   cnt  [NREG];
    logic [NREG-1:0] issue_hit;
    logic [NREG-1:0] retire_hit;
    logic [NREG-1:0] long_hit;
    logic [AW-1:0]   src  [NSRC];
    logic [1:0]      fwd  [NSRC];
    logic            src_hazard;
    logic            waw_full;
    logic            stall;
    logic [31:0]     stall_cnt_q;

    always_comb begin
        issue_hit  = '0;
        retire_hit = '0;
        long_hit   = '0;
        for (int r = 1; r < NREG; r++) begin
            issue_hit[r]  = bus.ds_issue & bus.ds_gr_we & (bus.ds_dest == AW'(r));
            retire_hit[r] = bus.ws_valid & bus.ws_gr_we & (bus.ws_dest == AW'(r))
                            & (pend[r] != 2'd0);
            long_hit[r]   = bus.long_done & (bus.long_dest == AW'(r));
        end
    end

    // cnt always tracks the youngest writer, so an issue overrides long_done and decrement
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (reset || bus.flush || (r == 0)) begin
                pend[r] <= 2'd0;
                cnt[r]  <= '0;
            end else begin
                case ({issue_hit[r], retire_hit[r]})
                    2'b10: if (pend[r] != 2'd3) pend[r] <= pend[r] + 2'd1;
                    2'b01: pend[r] <= pend[r] - 2'd1;
                    default: ;
                endcase
                if (issue_hit[r])
                    cnt[r] <= bus.ds_lat;
                else if (long_hit[r])
                    cnt[r] <= '0;
                else if (bus.pipe_go && (cnt[r] != '0) && (cnt[r] != LONG))
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    always_comb begin
        src_hazard  = 1'b0;
        bus.fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            src[i] = bus.ds_src[i*AW +: AW];
            fwd[i] = 2'b00;
            if (bus.ds_src_en[i] && (src[i] != '0)) begin
                if (bus.es_valid && bus.es_gr_we && (bus.es_dest == src[i]))
                    fwd[i] = 2'b01;
                else if (bus.ms_valid && bus.ms_gr_we && (bus.ms_dest == src[i]))
                    fwd[i] = 2'b10;
                else if (bus.ws_valid && bus.ws_gr_we && (bus.ws_dest == src[i]))
                    fwd[i] = 2'b11;
                // a branch resolves in decode and cannot wait for the EX result
                if ((pend[src[i]] != 2'd0) &&
                    ((cnt[src[i]] != '0) || (bus.ds_is_branch && (fwd[i] == 2'b01))))
                    src_hazard = 1'b1;
            end
            bus.fwd_sel[2*i +: 2] = fwd[i];
        end
        waw_full = bus.ds_gr_we && (pend[bus.ds_dest] == 2'd3);
        stall    = bus.ds_valid && (src_hazard || waw_full);
    end

    assign bus.ds_stall = stall;

    always_comb begin
        bus.sb_busy = '0;
        for (int r = 0; r < NREG; r++)
            bus.sb_busy[r] = (pend[r] != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scoreboard-queue bench for hazard_scoreboard
module tb_hazard_scoreboard;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NSRC = 2;
    localparam int CW   = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .CW(CW)) sb ();
    hazard_scoreboard #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          stalls = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL queue_underflow observed=%0h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic clr();
        sb.ds_valid = 0; sb.ds_issue = 0; sb.ds_src = '0; sb.ds_src_en = '0;
        sb.ds_is_branch = 0; sb.ds_gr_we = 0; sb.ds_dest = '0; sb.ds_lat = '0;
        sb.es_valid = 0; sb.es_gr_we = 0; sb.es_dest = '0;
        sb.ms_valid = 0; sb.ms_gr_we = 0; sb.ms_dest = '0;
        sb.ws_valid = 0; sb.ws_gr_we = 0; sb.ws_dest = '0;
        sb.pipe_go = 0; sb.long_done = 0; sb.long_dest = '0; sb.flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic issue_wr(input logic [AW-1:0] d, input logic [CW-1:0] lat);
        sb.ds_valid = 1; sb.ds_issue = 1; sb.ds_gr_we = 1; sb.ds_dest = d; sb.ds_lat = lat;
    endtask

    task automatic reader(input logic [AW-1:0] s0, input logic [AW-1:0] s1, input logic [1:0] en);
        sb.ds_valid = 1; sb.ds_src = {s1, s0}; sb.ds_src_en = en;
    endtask

    task automatic es(input logic [AW-1:0] d);
        sb.es_valid = 1; sb.es_gr_we = 1; sb.es_dest = d;
    endtask

    task automatic ms(input logic [AW-1:0] d);
        sb.ms_valid = 1; sb.ms_gr_we = 1; sb.ms_dest = d;
    endtask

    task automatic ws(input logic [AW-1:0] d);
        sb.ws_valid = 1; sb.ws_gr_we = 1; sb.ws_dest = d;
    endtask

    initial begin
        clr();
        reset = 1;
        step();
        step();
        reader(5, 0, 2'b01);
        push("rst_stall", 0); push("rst_fwd", 0); push("rst_busy", 0); push("rst_stall_cnt", 0);
        sample();
        pop_chk(sb.ds_stall); pop_chk(sb.fwd_sel); pop_chk(sb.sb_busy); pop_chk(sb.stall_cnt);
        reset = 0;

        // ALU write r5, reader forwards from EX
        step(); issue_wr(5, 0);
        push("t1_issue_stall", 0); sample(); pop_chk(sb.ds_stall);
        step(); reader(5, 0, 2'b01); sb.ds_issue = 1; es(5); sb.pipe_go = 1;
        push("t1_stall", 0); push("t1_fwd", 32'h1); push("t1_busy5", 1);
        sample(); pop_chk(sb.ds_stall); pop_chk(sb.fwd_sel); pop_chk(sb.sb_busy[5]);
        step(); ms(5); sb.pipe_go = 1;
        step(); ws(5); sb.pipe_go = 1;
        push("t1_busy5_wb", 1); sample(); pop_chk(sb.sb_busy[5]);
        step();
        push("t1_busy_clear", 0); sample(); pop_chk(sb.sb_busy);

        // load r8 with one-stage latency, consumer on source 1
        step(); issue_wr(8, 1); sb.pipe_go = 1;
        step(); reader(0, 8, 2'b10); es(8); sb.pipe_go = 1;
        push("t2_stall", 1); push("t2_fwd_ex", 32'h4);
        sample(); pop_chk(sb.ds_stall); pop_chk(sb.fwd_sel); stalls++;
        step(); reader(0, 8, 2'b10); ms(8); sb.pipe_go = 1; sb.ds_issue = 1;
        push("t2_stall_clear", 0); push("t2_fwd_mem", 32'h8); push("t2_stall_cnt", stalls);
        sample(); pop_chk(sb.ds_stall); pop_chk(sb.fwd_sel); pop_chk(sb.stall_cnt);
        step(); ws(8);
        step();

        // branch early-read hazard on r3
        step(); issue_wr(3, 0); sb.pipe_go = 1;
        step(); reader(3, 0, 2'b01); sb.ds_is_branch = 1; es(3); sb.pipe_go = 1;
        push("t3_br_stall", 1); push("t3_br_fwd_ex", 32'h1);
        sample(); pop_chk(sb.ds_stall); pop_chk(sb.fwd_sel); stalls++;
        step(); reader(3, 0, 2'b01); sb.ds_is_branch = 1; ms(3); sb.ds_issue = 1; sb.pipe_go = 1;
        push("t3_br_go", 0); push("t3_br_fwd_mem", 32'h2);
        sample(); pop_chk(sb.ds_stall); pop_chk(sb.fwd_sel);
        step(); reader(3, 0, 2'b01); ws(3);
        push("t3_wb_stall", 0); push("t3_fwd_wb", 32'h3);
        sample(); pop_chk(sb.ds_stall); pop_chk(sb.fwd_sel);
        step();

        // long op r10 holds through pipe_go until long_done
        step(); issue_wr(10, 3'b111);
        for (int k = 0; k < 20; k++) begin
            step(); reader(10, 0, 2'b01); sb.pipe_go = 1;
            push("t4_long_stall", 1); sample(); pop_chk(sb.ds_stall); stalls++;
        end
        step(); reader(10, 0, 2'b01); sb.long_done = 1; sb.long_dest = 10;
        push("t4_done_cycle_stall", 1); sample(); pop_chk(sb.ds_stall); stalls++;
        step(); reader(10, 0, 2'b01); sb.ds_issue = 1;
        push("t4_released", 0); push("t4_fwd_rf", 0); push("t4_stall_cnt", stalls);
        sample(); pop_chk(sb.ds_stall); pop_chk(sb.fwd_sel); pop_chk(sb.stall_cnt);
        step(); ws(10);
        step();

        // WAW: two writers to r4, older retires, younger count rules
        step(); issue_wr(4, 2);
        step(); issue_wr(4, 3);
        step(); ws(4);
        step(); reader(4, 0, 2'b01); sb.pipe_go = 1;
        push("t5_busy_after_retire", 1); push("t5_stall_cnt3", 1);
        sample(); pop_chk(sb.sb_busy[4]); pop_chk(sb.ds_stall); stalls++;
        step(); reader(4, 0, 2'b01); sb.pipe_go = 1;
        push("t5_stall_cnt2", 1); sample(); pop_chk(sb.ds_stall); stalls++;
        step(); reader(4, 0, 2'b01); sb.pipe_go = 1;
        push("t5_stall_cnt1", 1); sample(); pop_chk(sb.ds_stall); stalls++;
        step(); reader(4, 0, 2'b01);
        push("t5_younger_ready", 0); sample(); pop_chk(sb.ds_stall);
        step(); issue_wr(4, 0);
        step(); issue_wr(4, 0);
        step(); sb.ds_valid = 1; sb.ds_gr_we = 1; sb.ds_dest = 4;
        push("t5_waw_full", 1); sample(); pop_chk(sb.ds_stall); stalls++;
        step(); sb.ds_valid = 1; sb.ds_gr_we = 1; sb.ds_dest = 9;
        push("t5_waw_other", 0); sample(); pop_chk(sb.ds_stall);

        // flush with LONG r6 pending and concurrent issue/retire/long_done
        step(); issue_wr(6, 3'b111);
        step(); reader(6, 0, 2'b01);
        push("t6_long_stall", 1); sample(); pop_chk(sb.ds_stall); stalls++;
        step(); sb.flush = 1; issue_wr(7, 0); ws(4); sb.long_done = 1; sb.long_dest = 6;
        push("t6_flush_cycle_stall", 0); sample(); pop_chk(sb.ds_stall);
        step(); reader(6, 4, 2'b11); sb.ds_gr_we = 1; sb.ds_dest = 4;
        push("t6_busy", 0); push("t6_stall", 0); push("t6_stall_cnt", stalls);
        sample(); pop_chk(sb.sb_busy); pop_chk(sb.ds_stall); pop_chk(sb.stall_cnt);

        // mid-run reset
        step(); issue_wr(12, 3);
        step(); reset = 1;
        push("t7_busy_pre", 32'h0000_1000); sample(); pop_chk(sb.sb_busy);
        step(); reset = 0; reader(12, 0, 2'b01);
        push("t7_busy", 0); push("t7_stall_cnt", 0); push("t7_stall", 0);
        sample(); pop_chk(sb.sb_busy); pop_chk(sb.stall_cnt); pop_chk(sb.ds_stall);

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL queue_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
